// File: rtl/chocorrol_fetch.sv
// Instruction fetch/sequencer for the Chocorrol datapath: a writable instruction store plus a PC
// that streams a programmed number of words downstream over a valid/ready handshake.
module chocorrol_fetch #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 20
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          carga_en_i,
    input  logic [AW-1:0] carga_dir_i,
    input  logic [IW-1:0] carga_dato_i,
    input  logic          inicio_i,
    input  logic [AW:0]   longitud_i,
    input  logic          detener_i,
    input  logic          listo_i,
    output logic [IW-1:0] instruccion_o,
    output logic          valido_o,
    output logic [AW-1:0] pc_o,
    output logic          ocupado_o,
    output logic          fin_o,
    output logic          err_o,
    output logic          estado_o
);

    // Handshake: a word transfers on a rising edge where valido_o and listo_i are both high;
    // while valido_o is high and listo_i is low, instruccion_o and pc_o hold.
    typedef enum logic {
        INACTIVO = 1'b0,
        EJECUTA  = 1'b1
    } estado_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    estado_t       estado_q, estado_d;
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] instr_q, instr_d;
    logic          valido_q, valido_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;

    logic          wr_en;
    logic          len_ok;
    logic          xfer;
    logic          last;
    logic [AW-1:0] pc_inc;
    logic [IW-1:0] word0;

    assign wr_en  = (estado_q == INACTIVO) && carga_en_i;
    assign len_ok = (longitud_i != '0) && (longitud_i <= DEPTH_L);
    assign xfer   = valido_q && listo_i;
    assign last   = ({1'b0, cnt_q} == (len_q - (AW+1)'(1)));
    assign pc_inc = pc_q + AW'(1);
    // A write to address 0 in the same cycle as the start must be visible in the first word.
    assign word0  = (wr_en && (carga_dir_i == '0)) ? carga_dato_i : mem_q[0];

    // Store contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[carga_dir_i] <= carga_dato_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            estado_q <= INACTIVO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INACTIVO: begin
                if (inicio_i && len_ok) begin
                    estado_d = EJECUTA;
                end
            end
            EJECUTA: begin
                if (detener_i || (xfer && last)) begin
                    estado_d = INACTIVO;
                end
            end
            default: estado_d = INACTIVO;
        endcase
    end

    always_comb begin
        instr_d  = instr_q;
        valido_d = valido_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        fin_d    = 1'b0;
        err_d    = 1'b0;
        case (estado_q)
            INACTIVO: begin
                if (inicio_i) begin
                    if (len_ok) begin
                        len_d    = longitud_i;
                        pc_d     = '0;
                        cnt_d    = '0;
                        instr_d  = word0;
                        valido_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EJECUTA: begin
                // Abort wins over a simultaneous final transfer, so FIN stays low.
                if (detener_i) begin
                    valido_d = 1'b0;
                    pc_d     = '0;
                    cnt_d    = '0;
                end else if (xfer) begin
                    if (last) begin
                        valido_d = 1'b0;
                        pc_d     = '0;
                        cnt_d    = '0;
                        fin_d    = 1'b1;
                    end else begin
                        pc_d    = pc_inc;
                        cnt_d   = cnt_q + AW'(1);
                        instr_d = mem_q[pc_inc];
                    end
                end
            end
            default: begin
                valido_d = 1'b0;
                pc_d     = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_q  <= '0;
            valido_q <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            fin_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            valido_q <= valido_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
        end
    end

    assign instruccion_o = instr_q;
    assign valido_o      = valido_q;
    assign pc_o          = pc_q;
    assign ocupado_o     = (estado_q == EJECUTA);
    assign fin_o         = fin_q;
    assign err_o         = err_q;
    assign estado_o      = estado_q;

endmodule

// File: tb/tb_chocorrol_fetch.sv
// Bench for chocorrol_fetch: directed programs checked against a store/queue model every cycle,
// plus literal spot checks of known words, PCs and pulses.
module tb_chocorrol_fetch;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int IW    = 20;

    localparam logic [IW-1:0] W0 = 20'b01_00001_010_00010_00001;
    localparam logic [IW-1:0] W1 = 20'b10_00100_000_00011_00010;
    localparam logic [IW-1:0] W2 = 20'b10_00110_110_00101_00011;

    logic          clk, rst_n;
    logic          carga_en, inicio, detener, listo;
    logic [AW-1:0] carga_dir;
    logic [IW-1:0] carga_dato;
    logic [AW:0]   longitud;
    logic [IW-1:0] instruccion;
    logic          valido, ocupado, fin, err, estado;
    logic [AW-1:0] pc;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model: store image, queue of {pc, word} still owed downstream, and expected pulses.
    logic [IW-1:0]    store_m [DEPTH];
    logic [AW+IW-1:0] exp_q[$];
    logic             model_busy = 1'b0;
    logic             exp_fin    = 1'b0;
    logic             exp_err    = 1'b0;

    chocorrol_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .carga_en_i    (carga_en),
        .carga_dir_i   (carga_dir),
        .carga_dato_i  (carga_dato),
        .inicio_i      (inicio),
        .longitud_i    (longitud),
        .detener_i     (detener),
        .listo_i       (listo),
        .instruccion_o (instruccion),
        .valido_o      (valido),
        .pc_o          (pc),
        .ocupado_o     (ocupado),
        .fin_o         (fin),
        .err_o         (err),
        .estado_o      (estado)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // compare process: outputs checked at every negedge, then the model advances on the
    // inputs that the next rising edge will see
    always @(negedge clk) begin
        logic nfin, nerr;
        if (!rst_n) begin
            model_busy = 1'b0;
            exp_q.delete();
            exp_fin = 1'b0;
            exp_err = 1'b0;
            check("rst_outputs", {instruccion, valido, pc, ocupado, fin, err}, '0);
        end else begin
            check("valido", valido, model_busy);
            check("ocupado", ocupado, model_busy);
            check("fin", fin, exp_fin);
            check("err", err, exp_err);
            if (model_busy && valido && exp_q.size() > 0)
                check("word_pc", {pc, instruccion}, exp_q[0]);
            nfin = 1'b0;
            nerr = 1'b0;
            if (model_busy) begin
                if (listo) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        model_busy = 1'b0;
                        nfin = !detener;
                    end
                end
                if (detener) begin
                    model_busy = 1'b0;
                    exp_q.delete();
                end
            end else begin
                if (carga_en) store_m[carga_dir] = carga_dato;
                if (inicio) begin
                    if (longitud >= 1 && longitud <= DEPTH) begin
                        model_busy = 1'b1;
                        for (int i = 0; i < int'(longitud); i++)
                            exp_q.push_back({AW'(i), store_m[i]});
                    end else begin
                        nerr = 1'b1;
                    end
                end
            end
            exp_fin = nfin;
            exp_err = nerr;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        carga_en   = 1'b1;
        carga_dir  = AW'(addr);
        carga_dato = data;
        tick();
        carga_en = 1'b0;
    endtask

    task automatic start(input int len);
        inicio   = 1'b1;
        longitud = (AW+1)'(len);
        tick();
        inicio = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && ocupado; i++) tick();
        check("idle_timeout", ocupado, 1'b0);
        tick();
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; carga_en = 1'b0; carga_dir = '0; carga_dato = '0;
        inicio = 1'b0; longitud = '0; detener = 1'b0; listo = 1'b1;
        tick(); tick();
        check("reset_valido", valido, 1'b0);
        check("reset_pc", pc, 0);
        rst_n = 1'b1;
        tick();

        // 1: three-word program at full rate
        load(0, W0); load(1, W1); load(2, W2);
        start(3);
        check("t1_word0", instruccion, W0);
        check("t1_pc0", pc, 0);
        tick();
        check("t1_word1", instruccion, W1);
        tick();
        check("t1_word2", {pc, instruccion}, {5'd2, W2});
        tick();
        check("t1_fin", {fin, valido, ocupado}, 3'b100);
        tick();
        check("t1_fin_one_cycle", fin, 1'b0);

        // 2: stall two cycles on word 1
        start(3);
        tick();
        listo = 1'b0;
        tick();
        check("t2_hold", {pc, instruccion}, {5'd1, W1});
        tick();
        listo = 1'b1;
        wait_idle();

        // 3: illegal lengths
        start(0);
        check("t3_err0", {err, valido, ocupado}, 3'b100);
        tick();
        start(33);
        check("t3_err33", {err, valido, ocupado}, 3'b100);
        tick();

        // 4: full store, every word carries its index
        for (int i = 0; i < DEPTH; i++) load(i, {15'(i * 3 + 1), 5'(i)});
        start(32);
        for (int i = 0; i < 31; i++) tick();
        check("t4_last_pc", {pc, instruccion[4:0]}, {5'd31, 5'd31});
        tick();
        check("t4_fin_pc0", {fin, pc}, {1'b1, 5'd0});
        wait_idle();

        // 5: load and restart ignored mid-run, then abort on the final transfer
        load(0, W0); load(1, W1); load(2, W2);
        start(3);
        carga_en = 1'b1; carga_dir = 5'd2; carga_dato = 20'hABCDE;
        inicio = 1'b1; longitud = 6'd3;
        tick();
        carga_en = 1'b0; inicio = 1'b0;
        tick();
        detener = 1'b1;
        tick();
        detener = 1'b0;
        check("t5_abort", {valido, ocupado, fin, err, pc}, '0);
        tick();
        check("t5_no_fin", fin, 1'b0);

        // 6: reset while word 1 stalls, then replay
        start(3);
        tick();
        listo = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", {instruccion, valido, pc, ocupado, fin, err}, '0);
        tick();
        rst_n = 1'b1;
        listo = 1'b1;
        tick();
        start(3);
        tick(); tick();
        check("t6_replay_w2", instruccion, W2);
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
